// File: rtl/ascii_loader.sv
// ---------------------------------------------------------------------------
// ascii_loader
//
// Paced text-injection engine between the hps_io file-download port and the
// Apple-I keyboard input. Bytes from an OSD "Load Ascii" download are
// buffered in a FIFO. The host is throttled with ioctl_wait. The bytes are
// then replayed one at a time as single-cycle keystrobes, with line-ending,
// case and control-character translation. An idle gap is held after every
// emitted key, and a longer one after a carriage return, so that the
// Monitor/BASIC can keep up with line processing.
//
// Parameters
//   ADDR_W      FIFO address width, depth = 2**ADDR_W bytes
//   CHAR_DELAY  idle clk_sys cycles after each emitted key
//   CR_DELAY    idle clk_sys cycles after an emitted CR (>= CHAR_DELAY)
//   CNT_W       gap counter width, must hold CR_DELAY
//
// Ports
//   clk_sys         in   single clock, rising edge
//   reset           in   asynchronous, active-high, clears all state
//   ioctl_download  in   download in progress (already index-qualified)
//   ioctl_wr        in   one-cycle byte-valid strobe
//   ioctl_dout      in   download byte
//   ioctl_wait      out  registered backpressure to hps_io
//   upcase          in   map a-z to A-Z
//   filter          in   drop control bytes other than CR/LF, and bytes >= 0x80
//   abort           in   level; flushes the FIFO and stops playback
//   key_ready       in   keyboard port can accept a key
//   key_data        out  translated ASCII, bit 7 always 0
//   key_strobe      out  one-cycle pulse, key_data valid in the same cycle
//   busy            out  FIFO non-empty or FSM not idle
//   overflow        out  sticky, a write arrived while the FIFO was full
// ---------------------------------------------------------------------------
module ascii_loader #(
    parameter int ADDR_W     = 13,
    parameter int CHAR_DELAY = 25000,
    parameter int CR_DELAY   = 2500000,
    parameter int CNT_W      = 24
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_dout,
    output logic       ioctl_wait,
    input  logic       upcase,
    input  logic       filter,
    input  logic       abort,
    input  logic       key_ready,
    output logic [7:0] key_data,
    output logic       key_strobe,
    output logic       busy,
    output logic       overflow
);

    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    // Two entries of slack absorb hps_io writes already in flight when
    // ioctl_wait rises.
    localparam logic [ADDR_W:0]  WAIT_CNT = (ADDR_W + 1)'(DEPTH - 2);
    localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(CHAR_DELAY);
    localparam logic [CNT_W-1:0] CR_GAP   = CNT_W'(CR_DELAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_XLATE = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              dl_prev;
    logic              dl_rise;
    logic              flush;
    logic              wr_req;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_set;

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_byte_p1;
    logic [8:0]        xl_p1;
    logic [7:0]        key_pend_p2;
    logic [7:0]        key_hold;
    logic              last_cr;
    logic [CNT_W-1:0]  gap_cnt;

    // Pointers are kept modulo depth, so their top bit never toggles.
    logic              unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr[ADDR_W] ^ rd_ptr[ADDR_W];

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [ADDR_W:0] ptr_inc(input logic [ADDR_W:0] p);
        return {1'b0, p[ADDR_W-1:0] + ADDR_W'(1)};
    endfunction

    // Returns {keep, translated byte}. An LF right after a CR is the second
    // half of a CRLF pair and is discarded; a lone LF becomes CR because the
    // Apple-I only understands CR as end of line.
    function automatic logic [8:0] xlate_byte(
        input logic [7:0] b,
        input logic       prev_cr,
        input logic       up,
        input logic       filt
    );
        logic       keep;
        logic [7:0] c;
        keep = 1'b1;
        c    = b;
        if (b == 8'h0A) begin
            if (prev_cr)
                keep = 1'b0;
            else
                c = 8'h0D;
        end else begin
            if (filt && (b < 8'h20) && (b != 8'h0D))
                keep = 1'b0;
            if (filt && b[7])
                keep = 1'b0;
            if (up && (b >= 8'h61) && (b <= 8'h7A))
                c = b - 8'h20;
        end
        c[7] = 1'b0;
        return {keep, c};
    endfunction

    // -----------------------------------------------------------------------
    // Download edge detect and flush
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            dl_prev <= 1'b0;
        else
            dl_prev <= ioctl_download;
    end

    assign dl_rise = ioctl_download & ~dl_prev;
    assign flush   = dl_rise | abort;

    // A write coinciding with the flush edge is discarded along with the
    // rest of the old contents.
    assign wr_req  = ioctl_download & ioctl_wr & ~abort & ~dl_rise;
    assign wr_en   = wr_req & (count != FULL_CNT);
    assign ovf_set = wr_req & (count == FULL_CNT);

    // -----------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_next = count + (ADDR_W + 1)'(1);
                2'b01:   count_next = count - (ADDR_W + 1)'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            count      <= count_next;
            ioctl_wait <= (count_next >= WAIT_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (rd_en)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (dl_rise)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Stage p1: RAM with registered read, issued from FETCH
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= ioctl_dout;
        if (rd_en)
            rd_byte_p1 <= mem[rd_ptr[ADDR_W-1:0]];
    end

    assign xl_p1 = xlate_byte(rd_byte_p1, last_cr, upcase, filter);

    // -----------------------------------------------------------------------
    // Stage p2: translated key waiting in EMIT
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_pend_p2 <= 8'h00;
            last_cr     <= 1'b0;
        end else if (flush) begin
            last_cr     <= 1'b0;
        end else if (state == S_XLATE) begin
            key_pend_p2 <= xl_p1[7:0];
            last_cr     <= (rd_byte_p1 == 8'h0D);
        end
    end

    // key_data only changes on a strobe; between strobes the last key is
    // presented.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            key_hold <= 8'h00;
        else if (key_strobe)
            key_hold <= key_pend_p2;
    end

    // Inter-key gap; runs down in every state so the idle time overlaps the
    // FIFO being refilled.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if (flush)
            gap_cnt <= '0;
        else if (key_strobe)
            gap_cnt <= (key_pend_p2 == 8'h0D) ? CR_GAP : CHAR_GAP;
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - CNT_W'(1);
    end

    // -----------------------------------------------------------------------
    // Playback FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if ((count != '0) && (gap_cnt == '0)) state_next = S_FETCH;
            S_FETCH: state_next = S_XLATE;
            S_XLATE: state_next = xl_p1[8] ? S_EMIT : S_IDLE;
            S_EMIT:  if (key_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush)
            state_next = S_IDLE;
    end

    always_comb begin
        rd_en      = (state == S_FETCH) & ~flush;
        key_strobe = (state == S_EMIT) & key_ready & ~flush;
        key_data   = key_strobe ? key_pend_p2 : key_hold;
        busy       = (count != '0) | (state != S_IDLE);
    end

endmodule

// File: tb/tb_ascii_loader.sv
module tb_ascii_loader;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_dout;
    logic       ioctl_wait;
    logic       upcase;
    logic       filter;
    logic       abort;
    logic       key_ready;
    logic [7:0] key_data;
    logic       key_strobe;
    logic       busy;
    logic       overflow;

    always #5 clk_sys = ~clk_sys;

    ascii_loader #(
        .ADDR_W    (3),
        .CHAR_DELAY(4),
        .CR_DELAY  (20),
        .CNT_W     (8)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .upcase        (upcase),
        .filter        (filter),
        .abort         (abort),
        .key_ready     (key_ready),
        .key_data      (key_data),
        .key_strobe    (key_strobe),
        .busy          (busy),
        .overflow      (overflow)
    );

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] sq[$];
    int         st[$];
    logic [7:0] tx[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Strobe recorder: value and cycle of every keystrobe.
    always @(negedge clk_sys) begin
        if (key_strobe === 1'b1) begin
            sq.push_back(key_data);
            st.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic clear_log();
        sq.delete();
        st.delete();
    endtask

    task automatic start_download();
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
    endtask

    task automatic send_tx(input bit honour);
        int guard;
        guard = 0;
        while (tx.size() > 0 && guard < 2000) begin
            if (!honour || !ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_dout = tx.pop_front();
            end else begin
                ioctl_wr = 1'b0;
            end
            tick(1);
            guard++;
        end
        ioctl_wr = 1'b0;
        n_checks++;
        if (tx.size() != 0)
            $display("FAIL send_tx: %0d bytes left unsent, required 0", tx.size());
        else
            n_pass++;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c;
        c = 0;
        while (sq.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        n_checks++;
        if (sq.size() < n)
            $display("FAIL strobe_timeout: got %0d strobes, required %0d", sq.size(), n);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] got_key(input int i);
        if (i < sq.size())
            return sq[i];
        return 8'hEE;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_dout = 8'h00;
        upcase = 1'b0; filter = 1'b0; abort = 1'b0; key_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b required 0", ioctl_wait); else n_pass++;
        n_checks++; if (key_strobe !== 1'b0) $display("FAIL rst_strobe: got %b required 0", key_strobe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", overflow); else n_pass++;
        n_checks++; if (key_data !== 8'h00) $display("FAIL rst_key_data: got %h required 00", key_data); else n_pass++;
    endtask

    task automatic test_latency();
        int wcyc;
        clear_log();
        key_ready = 1'b1;
        start_download();
        wcyc = cyc;
        ioctl_wr = 1'b1; ioctl_dout = 8'h41;
        tick(1);
        ioctl_wr = 1'b0;
        wait_strobes(1, 20);
        n_checks++; if (got_key(0) !== 8'h41) $display("FAIL lat_value: got %h required 41", got_key(0)); else n_pass++;
        n_checks++;
        if (st.size() < 1 || st[0] != wcyc + 4)
            $display("FAIL lat_cycle: got %0d required %0d", (st.size() > 0) ? st[0] - wcyc : -1, 4);
        else
            n_pass++;
        tick(3);
        n_checks++; if (key_data !== 8'h41) $display("FAIL lat_hold: got %h required 41", key_data); else n_pass++;
        ioctl_download = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid_emit();
        clear_log();
        key_ready = 1'b0;
        start_download();
        ioctl_wr = 1'b1; ioctl_dout = 8'h55;
        tick(1);
        ioctl_wr = 1'b0;
        tick(6);
        n_checks++; if (busy !== 1'b1) $display("FAIL emit_busy: got %b required 1", busy); else n_pass++;
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick(2);
        reset = 1'b0;
        key_ready = 1'b1;
        tick(20);
        n_checks++; if (sq.size() != 0) $display("FAIL rst_emit_strobes: got %0d required 0", sq.size()); else n_pass++;
        n_checks++; if (key_data !== 8'h00) $display("FAIL rst_emit_key: got %h required 00", key_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_emit_busy: got %b required 0", busy); else n_pass++;
    endtask

    task automatic test_translate();
        logic [7:0] exp_k[4];
        int         need;
        exp_k = '{8'h41, 8'h0D, 8'h42, 8'h0D};
        clear_log();
        upcase = 1'b1; filter = 1'b0; key_ready = 1'b1;
        start_download();
        tx = '{8'h61, 8'h0A, 8'h42, 8'h0D, 8'h0A};
        send_tx(1'b1);
        ioctl_download = 1'b0;
        wait_strobes(4, 300);
        tick(60);
        n_checks++; if (sq.size() != 4) $display("FAIL xl_count: got %0d required 4", sq.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_key(i) !== exp_k[i]) $display("FAIL xl_key%0d: got %h required %h", i, got_key(i), exp_k[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            need = (exp_k[i] == 8'h0D) ? 24 : 8;
            n_checks++;
            if (st.size() < i + 2 || (st[i+1] - st[i]) < need)
                $display("FAIL xl_gap%0d: got %0d required >= %0d", i, (st.size() >= i + 2) ? st[i+1] - st[i] : -1, need);
            else
                n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL xl_busy: got %b required 0", busy); else n_pass++;
        upcase = 1'b0;
    endtask

    task automatic test_filter();
        clear_log();
        filter = 1'b1; key_ready = 1'b1;
        start_download();
        tx = '{8'h07, 8'h41, 8'hC1, 8'h09};
        send_tx(1'b1);
        ioctl_download = 1'b0;
        wait_strobes(1, 100);
        tick(40);
        n_checks++; if (sq.size() != 1) $display("FAIL flt_count: got %0d required 1", sq.size()); else n_pass++;
        n_checks++; if (got_key(0) !== 8'h41) $display("FAIL flt_key: got %h required 41", got_key(0)); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL flt_busy: got %b required 0", busy); else n_pass++;
        filter = 1'b0;
    endtask

    task automatic test_overflow();
        logic w_obs[10];
        logic o_obs[10];
        logic [7:0] exp_k;
        clear_log();
        key_ready = 1'b0;
        start_download();
        // Park one key in EMIT so the ten writes below only fill the FIFO.
        ioctl_wr = 1'b1; ioctl_dout = 8'h5A;
        tick(1);
        ioctl_wr = 1'b0;
        tick(6);
        for (int i = 0; i < 10; i++) begin
            ioctl_wr = 1'b1; ioctl_dout = 8'(8'h30 + i);
            tick(1);
            w_obs[i] = ioctl_wait;
            o_obs[i] = overflow;
        end
        ioctl_wr = 1'b0;
        n_checks++; if (w_obs[4] !== 1'b0) $display("FAIL ovf_wait5: got %b required 0", w_obs[4]); else n_pass++;
        n_checks++; if (w_obs[5] !== 1'b1) $display("FAIL ovf_wait6: got %b required 1", w_obs[5]); else n_pass++;
        n_checks++; if (o_obs[7] !== 1'b0) $display("FAIL ovf_at8: got %b required 0", o_obs[7]); else n_pass++;
        n_checks++; if (o_obs[8] !== 1'b1) $display("FAIL ovf_at9: got %b required 1", o_obs[8]); else n_pass++;
        ioctl_download = 1'b0;
        tick(2);
        key_ready = 1'b1;
        wait_strobes(9, 300);
        tick(30);
        n_checks++; if (sq.size() != 9) $display("FAIL ovf_count: got %0d required 9", sq.size()); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            exp_k = (i == 0) ? 8'h5A : 8'(8'h30 + i - 1);
            n_checks++;
            if (got_key(i) !== exp_k) $display("FAIL ovf_key%0d: got %h required %h", i, got_key(i), exp_k);
            else n_pass++;
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow); else n_pass++;
        n_checks++; if (ioctl_wait !== 1'b0) $display("FAIL ovf_wait_end: got %b required 0", ioctl_wait); else n_pass++;
    endtask

    task automatic test_wrap();
        clear_log();
        key_ready = 1'b1;
        start_download();
        n_checks++; if (overflow !== 1'b0) $display("FAIL wrap_ovf_clear: got %b required 0", overflow); else n_pass++;
        for (int i = 0; i < 20; i++) tx.push_back(8'(8'h41 + i));
        send_tx(1'b1);
        ioctl_download = 1'b0;
        wait_strobes(20, 600);
        tick(20);
        n_checks++; if (sq.size() != 20) $display("FAIL wrap_count: got %0d required 20", sq.size()); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (got_key(i) !== 8'(8'h41 + i)) $display("FAIL wrap_key%0d: got %h required %h", i, got_key(i), 8'(8'h41 + i));
            else n_pass++;
        end
        n_checks++; if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b required 0", overflow); else n_pass++;
    endtask

    task automatic test_abort();
        int guard;
        clear_log();
        key_ready = 1'b1;
        start_download();
        for (int i = 0; i < 10; i++) tx.push_back(8'(8'h30 + i));
        guard = 0;
        while (sq.size() < 3 && guard < 500) begin
            if (tx.size() > 0 && !ioctl_wait) begin
                ioctl_wr = 1'b1; ioctl_dout = tx.pop_front();
            end else begin
                ioctl_wr = 1'b0;
            end
            tick(1);
            guard++;
        end
        ioctl_wr = 1'b0;
        tx.delete();
        abort = 1'b1;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy_hi: got %b required 0", busy); else n_pass++;
        tick(1);
        abort = 1'b0;
        ioctl_download = 1'b0;
        tick(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b required 0", busy); else n_pass++;
        tick(60);
        n_checks++; if (sq.size() != 3) $display("FAIL abort_count: got %0d required 3", sq.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_key(i) !== 8'(8'h30 + i)) $display("FAIL abort_key%0d: got %h required %h", i, got_key(i), 8'(8'h30 + i));
            else n_pass++;
        end
        start_download();
        tx = '{8'h58, 8'h59};
        send_tx(1'b1);
        ioctl_download = 1'b0;
        wait_strobes(5, 100);
        n_checks++; if (got_key(3) !== 8'h58) $display("FAIL redl_key0: got %h required 58", got_key(3)); else n_pass++;
        n_checks++; if (got_key(4) !== 8'h59) $display("FAIL redl_key1: got %h required 59", got_key(4)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_reset_mid_emit();
        test_translate();
        test_filter();
        test_overflow();
        test_wrap();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_loader.md
# ascii_loader

Paced text-injection engine between the hps_io file-download port and the Apple-I keyboard input. It buffers ASCII bytes from an OSD "Load Ascii" download in a parametrised FIFO and throttles the host with `ioctl_wait`. It then replays the bytes as single-cycle keystrobes, applying line-ending, case and control-character translation, and holds a configurable gap between characters with a longer gap after each carriage return. This gives the Monitor/BASIC time to process each line.

## Interface
Parameters:
- `ADDR_W`, 13 — FIFO address width; depth = 2^ADDR_W bytes.
- `CHAR_DELAY`, 25000 — idle clk_sys cycles after each emitted key (1 ms at 25 MHz).
- `CR_DELAY`, 2500000 — idle cycles after an emitted CR (100 ms at 25 MHz); must be ≥ CHAR_DELAY.
- `CNT_W`, 24 — delay counter width; must hold CR_DELAY.

Ports:
- `clk_sys` in 1 — single clock; all logic is on the rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `ioctl_download` in 1 — download in progress; already qualified by ioctl_index.
- `ioctl_wr` in 1 — one-cycle byte-valid strobe.
- `ioctl_dout` in 8 — download byte.
- `ioctl_wait` out 1 — registered backpressure to hps_io.
- `upcase` in 1 — 1: map a–z to A–Z.
- `filter` in 1 — 1: drop control bytes other than CR/LF, and drop bytes ≥ 0x80.
- `abort` in 1 — level; flushes the FIFO and stops playback.
- `key_ready` in 1 — keyboard port can accept a key (PIA not holding an unread key).
- `key_data` out 8 — translated ASCII, bit 7 always 0.
- `key_strobe` out 1 — one-cycle pulse; `key_data` is valid in the same cycle.
- `busy` out 1 — FIFO non-empty or FSM not in IDLE.
- `overflow` out 1 — sticky; a write arrived while the FIFO was full.

## Operation
FIFO:
- Inferred single-clock RAM with registered read (1-cycle latency).
- `wr_ptr`, `rd_ptr` and `count` are each ADDR_W+1 bits; the pointers wrap modulo depth.
- A write is accepted when `ioctl_download & ioctl_wr & count != 2^ADDR_W`.
- A write while full is dropped and sets `overflow`. `overflow` clears only on reset or on a download rising edge.
- A download rising edge (registered compare) flushes the FIFO and the FSM to IDLE, clears `overflow` and zeroes `gap_cnt`.
- `abort` high has the same flush effect every cycle it is held. Writes are ignored while `abort` is high.
- A write and a read in the same cycle leave `count` unchanged.

FSM states:
- IDLE: if `count != 0` and `gap_cnt == 0` → FETCH.
- FETCH: issue the read at `rd_ptr`, increment `rd_ptr`, → XLATE.
- XLATE: evaluate the RAM output in this order:
  - LF (0x0A) immediately after an emitted or dropped CR → drop.
  - Otherwise LF → 0x0D.
  - `filter` and (byte < 0x20 excluding 0x0D) → drop.
  - `filter` and byte ≥ 0x80 → drop.
  - `upcase` and 0x61–0x7A → subtract 0x20.
  - Bit 7 is cleared.
  - A dropped byte → IDLE with no gap. A kept byte → EMIT.
  - `last_cr` is updated from the raw byte (1 iff the byte is 0x0D).
- EMIT: hold until `key_ready`. Then pulse `key_strobe`, load `gap_cnt` (CR_DELAY if `key_data == 0x0D`, else CHAR_DELAY) and go to IDLE.
- `gap_cnt` decrements by 1 each cycle while non-zero, in any state.

Playback continues after `ioctl_download` falls, until the FIFO drains.

## Timing
Reset values:
- `ioctl_wait`, `key_strobe`, `busy`, `overflow` = 0.
- `key_data` = 0x00.
- All pointers, `count`, `gap_cnt` = 0; `last_cr` = 0; FSM in IDLE.

`ioctl_wait`:
- Registered; high when `count ≥ 2^ADDR_W − 2`.
- The two slack entries absorb hps_io writes already in flight.

Latency:
- A byte written at cycle N into an empty FIFO, with the gap expired and `key_ready` high, strobes at cycle N+4:
  - N+1: `count` = 1.
  - N+1: IDLE→FETCH.
  - N+2: XLATE.
  - N+3: EMIT.
  - N+4: strobe.
- Minimum spacing between strobes is CHAR_DELAY + 4 cycles.

`key_data` holds its value between strobes. `abort` or reset during EMIT suppresses the pending strobe.

## Test plan
- Reset mid-EMIT with `key_ready` = 0, then release → no strobe, `key_data` = 0x00, `busy` = 0.
- Download "a\nB\r\n" with `upcase` = 1, CHAR_DELAY = 4, CR_DELAY = 20 → strobes 0x41, 0x0D, 0x42, 0x0D.
  - Strobe gaps ≥ 8 after non-CR keys and ≥ 24 after CR keys.
  - The trailing LF is dropped.
- `filter` = 1, input 0x07, 0x41, 0xC1, 0x09 → only 0x41 is strobed.
- ADDR_W = 3, `key_ready` = 0, ten back-to-back writes ignoring `ioctl_wait` → `ioctl_wait` high at `count` = 6, 8 bytes stored, `overflow` = 1.
  - Raising `key_ready` then plays back exactly the first 8 bytes in order.
- Pointer wrap: ADDR_W = 3, stream 20 bytes while honouring `ioctl_wait` → all 20 strobed in order, `overflow` = 0.
- `abort` pulse after 3 of 10 bytes have been strobed → no further strobes, `busy` = 0 one cycle after `abort` falls.
  - A new download rising edge then plays back normally.
